// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU sharing arbiter:
// ALU opcode constants and the sequencer state encoding.
package alu_share_arbiter_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ZERO = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for both clients of the shared ALU.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// the sender holds valid and its payload stable until that edge, and ready may depend on valid.
interface alu_share_arbiter_if;

    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [2:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [2:0]  req1_op;

    logic        resp0_valid;
    logic        resp0_ready;
    logic [31:0] resp0_c;
    logic        resp0_zero;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [31:0] resp1_c;
    logic        resp1_zero;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output resp0_ready, resp1_ready,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_c, resp0_zero,
        input  resp1_valid, resp1_c, resp1_zero
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  resp0_ready, resp1_ready,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_c, resp0_zero,
        output resp1_valid, resp1_c, resp1_zero
    );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU; zero reports operand equality regardless of opcode.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  alu_op_i,
    output logic [31:0] c_o,
    output logic        zero_o
);

    always_comb begin
        c_o = '0;
        case (alu_op_i)
            OP_AND:  c_o = a_i & b_i;
            OP_OR:   c_o = a_i | b_i;
            OP_ADD:  c_o = a_i + b_i;
            OP_ZERO: c_o = '0;
            OP_ANDN: c_o = a_i & ~b_i;
            OP_ORN:  c_o = a_i | ~b_i;
            OP_SUB:  c_o = a_i - b_i;
            OP_SLTU: c_o = {31'd0, (a_i < b_i)};
            default: c_o = '0;
        endcase
    end

    assign zero_o = (a_i == b_i);

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one ALU between two requesters: accept one op, execute from
// registered operands, hold the registered result until the issuer takes it.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_share_arbiter_if.slave   bus,
    output logic                 busy,
    output state_t               state_o
);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic [31:0] op_a_q, op_b_q;
    logic [2:0]  op_op_q;
    logic [31:0] resp_c_q;
    logic        resp_zero_q;

    logic        grant;
    logic        grant_vld;
    logic        accept;
    logic        resp_taken;
    logic [31:0] alu_c;
    logic        alu_zero;

    // On a tie, round-robin favours whoever did not win last time.
    always_comb begin
        grant_vld = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            grant = bus.req1_valid;
        end
    end

    assign bus.req0_ready = reset_n && (state_q == IDLE) && grant_vld && !grant;
    assign bus.req1_ready = reset_n && (state_q == IDLE) && grant_vld && grant;
    assign accept         = bus.req0_ready | bus.req1_ready;
    assign resp_taken     = owner_q ? bus.resp1_ready : bus.resp0_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    owner_d      = grant;
                    last_grant_d = grant;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (resp_taken) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_op_q     <= '0;
            resp_c_q    <= '0;
            resp_zero_q <= 1'b0;
        end else begin
            if (accept) begin
                op_a_q  <= grant ? bus.req1_a  : bus.req0_a;
                op_b_q  <= grant ? bus.req1_b  : bus.req0_b;
                op_op_q <= grant ? bus.req1_op : bus.req0_op;
            end
            if (state_q == EXEC) begin
                resp_c_q    <= alu_c;
                resp_zero_q <= alu_zero;
            end
        end
    end

    alu_share_arbiter_alu u_alu (
        .a_i      (op_a_q),
        .b_i      (op_b_q),
        .alu_op_i (op_op_q),
        .c_o      (alu_c),
        .zero_o   (alu_zero)
    );

    // Result registers are shared; only the owner's valid qualifies them.
    assign bus.resp0_valid = (state_q == RESP) && !owner_q;
    assign bus.resp1_valid = (state_q == RESP) && owner_q;
    assign bus.resp0_c     = resp_c_q;
    assign bus.resp1_c     = resp_c_q;
    assign bus.resp0_zero  = resp_zero_q;
    assign bus.resp1_zero  = resp_zero_q;

    assign busy    = (state_q != IDLE);
    assign state_o = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin and a fixed-priority instance share
// one stimulus bus; a mux picks which instance the current test observes.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        use_fp;
    logic        d_req0_valid, d_req1_valid, d_resp0_ready, d_resp1_ready;
    logic [31:0] d_req0_a, d_req0_b, d_req1_a, d_req1_b;
    logic [2:0]  d_req0_op, d_req1_op;

    alu_share_arbiter_if rr();
    alu_share_arbiter_if fp();

    assign rr.req0_valid  = d_req0_valid;
    assign rr.req0_a      = d_req0_a;
    assign rr.req0_b      = d_req0_b;
    assign rr.req0_op     = d_req0_op;
    assign rr.req1_valid  = d_req1_valid;
    assign rr.req1_a      = d_req1_a;
    assign rr.req1_b      = d_req1_b;
    assign rr.req1_op     = d_req1_op;
    assign rr.resp0_ready = d_resp0_ready;
    assign rr.resp1_ready = d_resp1_ready;
    assign fp.req0_valid  = d_req0_valid;
    assign fp.req0_a      = d_req0_a;
    assign fp.req0_b      = d_req0_b;
    assign fp.req0_op     = d_req0_op;
    assign fp.req1_valid  = d_req1_valid;
    assign fp.req1_a      = d_req1_a;
    assign fp.req1_b      = d_req1_b;
    assign fp.req1_op     = d_req1_op;
    assign fp.resp0_ready = d_resp0_ready;
    assign fp.resp1_ready = d_resp1_ready;

    logic   rr_busy, fp_busy;
    state_t rr_state, fp_state;

    alu_share_arbiter #(.FIXED_PRIO(0)) dut_rr (
        .clk(clk), .reset_n(reset_n), .bus(rr.slave), .busy(rr_busy), .state_o(rr_state)
    );

    alu_share_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset_n(reset_n), .bus(fp.slave), .busy(fp_busy), .state_o(fp_state)
    );

    logic        s_req0_ready, s_req1_ready, s_resp0_valid, s_resp1_valid;
    logic [31:0] s_resp0_c, s_resp1_c;
    logic        s_resp0_zero, s_resp1_zero, s_busy;
    state_t      s_state;

    assign s_req0_ready  = use_fp ? fp.req0_ready  : rr.req0_ready;
    assign s_req1_ready  = use_fp ? fp.req1_ready  : rr.req1_ready;
    assign s_resp0_valid = use_fp ? fp.resp0_valid : rr.resp0_valid;
    assign s_resp1_valid = use_fp ? fp.resp1_valid : rr.resp1_valid;
    assign s_resp0_c     = use_fp ? fp.resp0_c     : rr.resp0_c;
    assign s_resp1_c     = use_fp ? fp.resp1_c     : rr.resp1_c;
    assign s_resp0_zero  = use_fp ? fp.resp0_zero  : rr.resp0_zero;
    assign s_resp1_zero  = use_fp ? fp.resp1_zero  : rr.resp1_zero;
    assign s_busy        = use_fp ? fp_busy        : rr_busy;
    assign s_state       = use_fp ? fp_state       : rr_state;

    int checks = 0;
    int passed = 0;

    // Reference ALU straight from the opcode table; returns {zero, c}.
    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [31:0] c;
        case (op)
            3'd0:    c = a & b;
            3'd1:    c = a | b;
            3'd2:    c = a + b;
            3'd3:    c = 32'd0;
            3'd4:    c = a & ~b;
            3'd5:    c = a | ~b;
            3'd6:    c = a - b;
            3'd7:    c = (a < b) ? 32'd1 : 32'd0;
            default: c = 32'd0;
        endcase
        return {(a == b), c};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        d_req0_valid = 1'b0; d_req1_valid = 1'b0;
        d_resp0_ready = 1'b0; d_resp1_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Presents one request and waits for its acceptance; returns after the accepting edge.
    task automatic issue(input bit n, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, output int waited);
        waited = -1;
        @(negedge clk);
        if (n) begin
            d_req1_valid = 1'b1; d_req1_a = a; d_req1_b = b; d_req1_op = op;
        end else begin
            d_req0_valid = 1'b1; d_req0_a = a; d_req0_b = b; d_req0_op = op;
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if (n ? s_req1_ready : s_req0_ready) begin
                waited = i;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (n) d_req1_valid = 1'b0;
        else   d_req0_valid = 1'b0;
    endtask

    // Waits for requester n's response, returns {zero, c} and cycles since acceptance, then consumes it.
    task automatic collect(input bit n, output int lat, output logic [32:0] res);
        lat = -1;
        res = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (n ? s_resp1_valid : s_resp0_valid) begin
                lat = i;
                res = n ? {s_resp1_zero, s_resp1_c} : {s_resp0_zero, s_resp0_c};
                break;
            end
        end
        if (n) d_resp1_ready = 1'b1;
        else   d_resp0_ready = 1'b1;
        @(posedge clk);
        #1;
        d_resp0_ready = 1'b0;
        d_resp1_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int w;
        int seen;
        use_fp = 1'b0;
        reset_n = 1'b0;
        d_req0_valid = 1'b1; d_req0_a = 32'h5; d_req0_b = 32'h5; d_req0_op = 3'b010;
        d_req1_valid = 1'b1; d_req1_a = 32'h6; d_req1_b = 32'h7; d_req1_op = 3'b000;
        @(negedge clk);
        #1;
        checks++; if ({s_req0_ready, s_req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {s_req0_ready, s_req1_ready}); else passed++;
        checks++; if ({s_resp0_valid, s_resp1_valid} !== 2'b00) $display("FAIL reset_resp_valid: got %b want 00", {s_resp0_valid, s_resp1_valid}); else passed++;
        checks++; if (s_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", s_busy); else passed++;
        checks++; if (s_state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", s_state); else passed++;
        checks++; if ({s_resp0_zero, s_resp0_c} !== 33'd0) $display("FAIL reset_result: got %h want 0", {s_resp0_zero, s_resp0_c}); else passed++;
        d_req0_valid = 1'b0; d_req1_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        issue(1'b0, 32'h7, 32'h9, 3'b010, w);
        checks++; if (s_busy !== 1'b1) $display("FAIL inflight_busy: got %b want 1", s_busy); else passed++;
        reset_n = 1'b0;
        #1;
        checks++; if ({s_state == IDLE, s_busy, s_resp0_valid, s_req0_ready} !== 4'b1000) $display("FAIL midreset_outputs: got %b want 1000", {s_state == IDLE, s_busy, s_resp0_valid, s_req0_ready}); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (s_resp0_valid || s_resp1_valid || s_busy) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL no_stale_resp: got %0d active cycles want 0", seen); else passed++;
    endtask

    task automatic test_single_add();
        int w, lat;
        logic [32:0] res;
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 3'b010, w);
        checks++; if (w !== 0) $display("FAIL add_accept_wait: got %0d want 0", w); else passed++;
        collect(1'b0, lat, res);
        checks++; if (lat !== 1) $display("FAIL add_latency: got %0d want 1", lat); else passed++;
        checks++; if (res !== {1'b0, 32'h0000_0001}) $display("FAIL add_result: got %h want %h", res, {1'b0, 32'h1}); else passed++;
        #1;
        checks++; if (s_busy !== 1'b0) $display("FAIL add_idle_after: got %b want 0", s_busy); else passed++;
    endtask

    task automatic test_sltu_zero();
        int w, lat;
        logic [32:0] res;
        issue(1'b1, 32'h8000_0000, 32'h0000_0001, 3'b111, w);
        collect(1'b1, lat, res);
        checks++; if (res !== 33'd0) $display("FAIL sltu_result: got %h want 0", res); else passed++;
        checks++; if (lat !== 1) $display("FAIL sltu_latency: got %0d want 1", lat); else passed++;
        issue(1'b1, 32'h1234, 32'h1234, 3'b110, w);
        collect(1'b1, lat, res);
        checks++; if (res !== {1'b1, 32'd0}) $display("FAIL sub_zero_result: got %h want %h", res, {1'b1, 32'd0}); else passed++;
    endtask

    task automatic test_backpressure();
        int w, lat, bad;
        logic [31:0] held;
        logic [32:0] res;
        issue(1'b0, 32'hA5A5_0F0F, 32'h0F0F_FFFF, 3'b101, w);
        d_req1_valid = 1'b1; d_req1_a = 32'd100; d_req1_b = 32'd58; d_req1_op = 3'b110;
        @(negedge clk);
        #1;
        checks++; if (s_req1_ready !== 1'b0) $display("FAIL bp_exec_ready: got %b want 0", s_req1_ready); else passed++;
        @(negedge clk);
        #1;
        held = s_resp0_c;
        checks++; if ({s_resp0_zero, held} !== alu_ref(32'hA5A5_0F0F, 32'h0F0F_FFFF, 3'b101)) $display("FAIL bp_result: got %h want %h", {s_resp0_zero, held}, alu_ref(32'hA5A5_0F0F, 32'h0F0F_FFFF, 3'b101)); else passed++;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (s_state !== RESP || s_resp0_valid !== 1'b1 || s_resp0_c !== held || s_req1_ready !== 1'b0 || s_resp1_valid !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL bp_hold: got %0d bad cycles want 0", bad); else passed++;
        d_resp0_ready = 1'b1;
        @(posedge clk);
        #1;
        d_resp0_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (s_req1_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", s_req1_ready); else passed++;
        @(posedge clk);
        #1;
        d_req1_valid = 1'b0;
        collect(1'b1, lat, res);
        checks++; if (res !== {1'b0, 32'd42} || lat !== 1) $display("FAIL bp_req1_result: got %h lat %0d want %h lat 1", res, lat, {1'b0, 32'd42}); else passed++;
    endtask

    // Streams n0/n1 random ops; model: an idle arbiter grants the sole valid requester,
    // on a tie the one that did not win last (or requester 0 when fixed), one op in flight at a time.
    task automatic test_traffic(input string name, input bit fixed, input int n0, input int n1, input bit rnd);
        int rem0, rem1, got0, got1, last_g, acc_cyc, eg;
        int both_ready, bad_ready, bad_grant, bad_data, bad_lat;
        bit outstanding, first_seen, r0, r1, exp_any;
        logic [32:0] exp0[$];
        logic [32:0] exp1[$];
        use_fp = fixed;
        apply_reset();
        rem0 = n0; rem1 = n1; got0 = 0; got1 = 0; last_g = 1; acc_cyc = 0;
        both_ready = 0; bad_ready = 0; bad_grant = 0; bad_data = 0; bad_lat = 0;
        outstanding = 1'b0; first_seen = 1'b0;
        d_resp0_ready = 1'b1; d_resp1_ready = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (got0 == n0 && got1 == n1) break;
            @(negedge clk);
            if (!d_req0_valid && rem0 > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
                d_req0_a = $urandom;
                d_req0_b = ($urandom_range(0, 3) == 0) ? d_req0_a : $urandom;
                d_req0_op = 3'($urandom_range(0, 7));
                d_req0_valid = 1'b1;
            end
            if (!d_req1_valid && rem1 > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
                d_req1_a = $urandom;
                d_req1_b = ($urandom_range(0, 3) == 0) ? d_req1_a : $urandom;
                d_req1_op = 3'($urandom_range(0, 7));
                d_req1_valid = 1'b1;
            end
            if (rnd) begin
                d_resp0_ready = 1'($urandom_range(0, 1));
                d_resp1_ready = 1'($urandom_range(0, 1));
            end
            #1;
            r0 = s_req0_ready;
            r1 = s_req1_ready;
            if (r0 && r1) both_ready++;
            exp_any = !outstanding && (d_req0_valid || d_req1_valid);
            if ((r0 || r1) != exp_any) bad_ready++;
            if ((r0 || r1) && !(r0 && r1)) begin
                if (d_req0_valid && d_req1_valid) eg = fixed ? 0 : 1 - last_g;
                else eg = d_req0_valid ? 0 : 1;
                if ((r1 ? 1 : 0) != eg) bad_grant++;
                if (r1) exp1.push_back(alu_ref(d_req1_a, d_req1_b, d_req1_op));
                else    exp0.push_back(alu_ref(d_req0_a, d_req0_b, d_req0_op));
                last_g = r1 ? 1 : 0;
                outstanding = 1'b1;
                acc_cyc = cyc;
                first_seen = 1'b0;
            end
            if (s_resp0_valid && s_resp1_valid) bad_data++;
            if (s_resp0_valid) begin
                if (!first_seen && cyc - acc_cyc != 2) bad_lat++;
                first_seen = 1'b1;
                if (exp0.size() == 0 || {s_resp0_zero, s_resp0_c} !== exp0[0]) bad_data++;
                if (d_resp0_ready) begin
                    if (exp0.size() > 0) void'(exp0.pop_front());
                    got0++;
                    outstanding = 1'b0;
                end
            end
            if (s_resp1_valid) begin
                if (!first_seen && cyc - acc_cyc != 2) bad_lat++;
                first_seen = 1'b1;
                if (exp1.size() == 0 || {s_resp1_zero, s_resp1_c} !== exp1[0]) bad_data++;
                if (d_resp1_ready) begin
                    if (exp1.size() > 0) void'(exp1.pop_front());
                    got1++;
                    outstanding = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            if (r0 && !r1) begin d_req0_valid = 1'b0; rem0--; end
            if (r1 && !r0) begin d_req1_valid = 1'b0; rem1--; end
        end
        d_req0_valid = 1'b0; d_req1_valid = 1'b0;
        d_resp0_ready = 1'b0; d_resp1_ready = 1'b0;
        checks++; if (both_ready !== 0) $display("FAIL %s both_ready: got %0d cycles want 0", name, both_ready); else passed++;
        checks++; if (bad_ready !== 0) $display("FAIL %s ready_timing: got %0d bad cycles want 0", name, bad_ready); else passed++;
        checks++; if (bad_grant !== 0) $display("FAIL %s grant_order: got %0d wrong grants want 0", name, bad_grant); else passed++;
        checks++; if (bad_data !== 0) $display("FAIL %s resp_data: got %0d bad responses want 0", name, bad_data); else passed++;
        checks++; if (bad_lat !== 0) $display("FAIL %s resp_latency: got %0d late/early want 0", name, bad_lat); else passed++;
        checks++; if (got0 !== n0) $display("FAIL %s resp0_count: got %0d want %0d", name, got0, n0); else passed++;
        checks++; if (got1 !== n1) $display("FAIL %s resp1_count: got %0d want %0d", name, got1, n1); else passed++;
    endtask

    task automatic test_round_robin();
        test_traffic("round_robin", 1'b0, 4, 4, 1'b0);
    endtask

    task automatic test_fixed_prio();
        test_traffic("fixed_prio", 1'b1, 3, 2, 1'b0);
    endtask

    task automatic test_random();
        test_traffic("random_rr", 1'b0, 12, 12, 1'b1);
        test_traffic("random_fp", 1'b1, 8, 8, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        use_fp = 1'b0;
        d_req0_valid = 1'b0; d_req1_valid = 1'b0;
        d_resp0_ready = 1'b0; d_resp1_ready = 1'b0;
        d_req0_a = '0; d_req0_b = '0; d_req0_op = '0;
        d_req1_a = '0; d_req1_b = '0; d_req1_op = '0;
        test_reset();
        test_single_add();
        test_sltu_zero();
        test_backpressure();
        test_round_robin();
        test_fixed_prio();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
